// File: rtl/disp_col_window_5x5.sv
// Horizontal 5x5 window former: shifts disparity columns into a 5-deep window
// with left/right border replication and emits one window per pixel.
module disp_col_window_5x5 #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 5,
  parameter int unsigned AWIDTH = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clken,
  input  logic [AWIDTH-1:0]            img_width,
  input  logic [WIDTH*ROWS-1:0]        col_in,
  input  logic                         col_valid,
  output logic [WIDTH*ROWS*COLS-1:0]   win_out,
  output logic                         win_valid,
  output logic [AWIDTH-1:0]            center_x,
  output logic                         line_end,
  output logic                         overrun
);

  localparam int unsigned COL_W = WIDTH * ROWS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FLUSH1 = 2'd2,
    FLUSH2 = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    w_q [COLS];
  logic [COL_W-1:0]    w_d [COLS];
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic                win_valid_d;
  logic [AWIDTH-1:0]   center_x_d;
  logic                line_end_d;
  logic                overrun_d;
  logic [AWIDTH-1:0]   last_x;
  logic [AWIDTH-1:0]   penult_x;

  assign last_x   = AWIDTH'(img_width - AWIDTH'(1));
  assign penult_x = AWIDTH'(img_width - AWIDTH'(2));

  // Window output: column j of the window is register W[j], j=0 is x-2
  for (genvar j = 0; j < COLS; j++) begin : g_win
    assign win_out[j*COL_W +: COL_W] = w_q[j];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (clken) begin
      state_q <= state_d;
    end
  end

  // Next-state, window shift, counter and output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    win_valid_d = 1'b0;
    center_x_d  = center_x;
    line_end_d  = 1'b0;
    overrun_d   = overrun;

    case (state_q)
      IDLE, RUN: begin
        if (col_valid) begin
          if (cnt_q == '0) begin
            for (int j = 0; j < COLS; j++) w_d[j] = col_in;
            state_d = RUN;
          end else begin
            for (int j = 0; j < COLS - 1; j++) w_d[j] = w_q[j+1];
            w_d[COLS-1] = col_in;
          end
          if (cnt_q >= AWIDTH'(2)) begin
            win_valid_d = 1'b1;
            center_x_d  = AWIDTH'(cnt_q - AWIDTH'(2));
          end
          if (cnt_q == last_x) begin
            cnt_d   = '0;
            state_d = FLUSH1;
          end else begin
            cnt_d = AWIDTH'(cnt_q + AWIDTH'(1));
          end
        end
      end
      FLUSH1, FLUSH2: begin
        // Right-border replicate: newest column stays in W4
        for (int j = 0; j < COLS - 1; j++) w_d[j] = w_q[j+1];
        w_d[COLS-1] = w_q[COLS-1];
        win_valid_d = 1'b1;
        if (col_valid) overrun_d = 1'b1;
        if (state_q == FLUSH1) begin
          center_x_d = penult_x;
          state_d    = FLUSH2;
        end else begin
          center_x_d = last_x;
          line_end_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < COLS; j++) w_q[j] <= '0;
      cnt_q     <= '0;
      win_valid <= 1'b0;
      center_x  <= '0;
      line_end  <= 1'b0;
      overrun   <= 1'b0;
    end else if (clken) begin
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      win_valid <= win_valid_d;
      center_x  <= center_x_d;
      line_end  <= line_end_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_disp_col_window_5x5.sv
// Directed bench for the 5x5 column window former.
module tb_disp_col_window_5x5;

  logic         clk = 1'b0;
  logic         rst;
  logic         clken;
  logic [10:0]  img_width;
  logic [79:0]  col_in;
  logic         col_valid;
  logic [399:0] win_out;
  logic         win_valid;
  logic [10:0]  center_x;
  logic         line_end;
  logic         overrun;

  int total = 0;
  int bad   = 0;
  logic [399:0] win_log [0:7];

  disp_col_window_5x5 dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .img_width (img_width),
    .col_in    (col_in),
    .col_valid (col_valid),
    .win_out   (win_out),
    .win_valid (win_valid),
    .center_x  (center_x),
    .line_end  (line_end),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // One comparison point
  task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Column k in pattern mode: 0 all samples k, 1 all samples k+10, 2 three-line column
  function automatic logic [79:0] col_of(input int mode, input int k);
    logic [79:0] c;
    c = '0;
    for (int r = 0; r < 5; r++) begin
      case (mode)
        0:       c[16*r +: 16] = 16'(k);
        1:       c[16*r +: 16] = 16'(k + 10);
        default: if (r >= 2) c[16*r +: 16] = 16'(k * 8 + r);
      endcase
    end
    return c;
  endfunction

  // Reference window centred on x with border clamping
  function automatic logic [399:0] exp_win(input int mode, input int x, input int w);
    logic [399:0] v;
    int s;
    v = '0;
    for (int j = 0; j < 5; j++) begin
      s = x - 2 + j;
      if (s < 0) s = 0;
      if (s > w - 1) s = w - 1;
      v[80*j +: 80] = col_of(mode, s);
    end
    return v;
  endfunction

  function automatic logic [399:0] win5(input int a, input int b, input int c, input int d, input int e);
    return {col_of(0, e), col_of(0, d), col_of(0, c), col_of(0, b), col_of(0, a)};
  endfunction

  task automatic tick(input logic ce, input logic v, input logic [79:0] data);
    clken     = ce;
    col_valid = v;
    col_in    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic log_win();
    if (win_valid && center_x < 11'd8) win_log[center_x[2:0]] = win_out;
  endtask

  // Feed a full line back-to-back, flush, and check every window
  task automatic run_line(input int mode, input int w);
    int pulses;
    pulses = 0;
    img_width = 11'(w);
    for (int k = 0; k < w; k++) begin
      tick(1'b1, 1'b1, col_of(mode, k));
      if (win_valid) pulses++;
      log_win();
      check("run_valid", 400'(win_valid), 400'(k >= 2));
      check("run_line_end", 400'(line_end), 400'(0));
      if (k >= 2) begin
        check("run_center", 400'(center_x), 400'(k - 2));
        check("run_win", win_out, exp_win(mode, k - 2, w));
      end
    end
    for (int f = 0; f < 2; f++) begin
      tick(1'b1, 1'b0, '0);
      if (win_valid) pulses++;
      log_win();
      check("flush_valid", 400'(win_valid), 400'(1));
      check("flush_center", 400'(center_x), 400'(w - 2 + f));
      check("flush_win", win_out, exp_win(mode, w - 2 + f, w));
      check("flush_line_end", 400'(line_end), 400'(f == 1));
    end
    tick(1'b1, 1'b0, '0);
    check("idle_valid", 400'(win_valid), 400'(0));
    check("idle_line_end", 400'(line_end), 400'(0));
    check("pulse_count", 400'(pulses), 400'(w));
  endtask

  initial begin
    logic [399:0] pw;
    logic         pv, pl, po;
    logic [10:0]  pc;
    logic         ce, v;
    int           k, n, nx;

    rst = 1'b1; clken = 1'b1; col_valid = 1'b0; col_in = '0; img_width = 11'd8;
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check("rst_win", win_out, '0);
    check("rst_valid", 400'(win_valid), 400'(0));
    check("rst_center", 400'(center_x), 400'(0));
    check("rst_line_end", 400'(line_end), 400'(0));
    check("rst_overrun", 400'(overrun), 400'(0));
    rst = 1'b0;

    // 8-wide line
    run_line(0, 8);
    check("w8_x0", win_log[0], win5(0, 0, 0, 1, 2));
    check("w8_x7", win_log[7], win5(5, 6, 7, 7, 7));

    // 3-wide line
    run_line(0, 3);
    check("w3_x0", win_log[0], win5(0, 0, 0, 1, 2));
    check("w3_x1", win_log[1], win5(0, 0, 1, 2, 2));
    check("w3_x2", win_log[2], win5(0, 1, 2, 2, 2));

    // 1920-wide line with random gaps and clock-enable holes
    img_width = 11'd1920;
    k = 0; n = 0; nx = 0;
    for (int cyc = 0; cyc < 20000 && n < 1920; cyc++) begin
      ce = ($urandom_range(0, 3) != 0);
      v  = (k < 1920) && ($urandom_range(0, 2) != 0);
      pw = win_out; pv = win_valid; pc = center_x; pl = line_end; po = overrun;
      tick(ce, v, col_of(0, k));
      if (ce && v) k++;
      if (!ce) begin
        check("hold_win", win_out, pw);
        check("hold_ctl", 400'({win_valid, center_x, line_end, overrun}), 400'({pv, pc, pl, po}));
      end else if (win_valid) begin
        check("rnd_center", 400'(center_x), 400'(nx));
        check("rnd_win", win_out, exp_win(0, nx, 1920));
        check("rnd_line_end", 400'(line_end), 400'(nx == 1919));
        n++; nx++;
      end
    end
    check("rnd_count", 400'(n), 400'(1920));
    check("rnd_no_overrun", 400'(overrun), 400'(0));
    tick(1'b1, 1'b0, '0);

    // Column during flush
    img_width = 11'd8;
    for (int c = 0; c < 8; c++) tick(1'b1, 1'b1, col_of(0, c));
    tick(1'b1, 1'b1, col_of(0, 99));
    check("ovr_win1", win_out, win5(4, 5, 6, 7, 7));
    check("ovr_center1", 400'(center_x), 400'(6));
    check("ovr_flag1", 400'(overrun), 400'(1));
    tick(1'b1, 1'b0, '0);
    check("ovr_win2", win_out, win5(5, 6, 7, 7, 7));
    check("ovr_center2", 400'(center_x), 400'(7));
    check("ovr_line_end", 400'(line_end), 400'(1));
    check("ovr_flag2", 400'(overrun), 400'(1));
    tick(1'b1, 1'b0, '0);
    check("ovr_flag3", 400'(overrun), 400'(1));
    check("ovr_idle_valid", 400'(win_valid), 400'(0));

    // Reset in mid-line, then restart
    for (int c = 0; c < 5; c++) tick(1'b1, 1'b1, col_of(0, c));
    rst = 1'b1;
    tick(1'b1, 1'b0, '0);
    rst = 1'b0;
    check("mid_rst_win", win_out, '0);
    check("mid_rst_valid", 400'(win_valid), 400'(0));
    check("mid_rst_center", 400'(center_x), 400'(0));
    check("mid_rst_line_end", 400'(line_end), 400'(0));
    check("mid_rst_overrun", 400'(overrun), 400'(0));
    run_line(1, 8);
    check("restart_x0", win_log[0], {col_of(1, 2), col_of(1, 1), col_of(1, 0), col_of(1, 0), col_of(1, 0)});

    // Three-line columns: rows 0-1 stay zero in every window position
    run_line(2, 5);
    for (int x = 0; x < 5; x++) begin
      for (int j = 0; j < 5; j++) begin
        check("row01_zero", 400'(win_log[x][80*j +: 32]), 400'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_col_window_5x5.md
# disp_col_window_5x5

Horizontal window former for the post-processing window path. It consumes one 5-row disparity column per pixel from the right-disparity line buffer (80-bit column plus valid) and assembles a 5x5 window centred on each pixel, replicating columns at the left and right borders. It emits exactly `img_width` windows per line, in pixel order, and feeds the 5x5 window filters downstream. After the last column of a line it runs a two-cycle right-border flush.

## Interface
- `WIDTH`, 16, bits per disparity sample
- `ROWS`, 5, rows per column (fixed; 3-line columns arrive with the low two rows zeroed and pass through unchanged)
- `COLS`, 5, window columns (fixed)
- `AWIDTH`, 11, column counter width
- `clk`  input  1  clock
- `rst`  input  1  synchronous, active-high reset
- `clken`  input  1  global clock enable; all state holds when low
- `img_width`  input  11  pixels per line, 3..1920, static within a frame
- `col_in`  input  WIDTH*ROWS  column; `[16r+15:16r]` = row r, row 4 = newest line
- `col_valid`  input  1  column present this clken cycle
- `win_out`  output  WIDTH*ROWS*COLS  window; `[80j+79:80j]` = column j, j=0 is x-2, j=4 is x+2
- `win_valid`  output  1  window valid (qualified by clken)
- `center_x`  output  AWIDTH  x coordinate of the window centre
- `line_end`  output  1  high with the window whose `center_x` = `img_width`-1
- `overrun`  output  1  sticky; a column arrived during flush

## Operation
- Internal state: column registers W0..W4, column counter `cnt` (0..img_width-1), and a state machine with states IDLE, RUN, FLUSH1, FLUSH2.
- An "accept" is a cycle with `clken`=1, `col_valid`=1, and state IDLE or RUN.
- Accept with `cnt`=0 (first column of a line):
  - W0..W4 <= `col_in` (left-border replicate).
  - State -> RUN.
- Accept with `cnt`>0:
  - Shift W0<=W1, W1<=W2, W2<=W3, W3<=W4, W4<=`col_in`.
- Counter on every accept:
  - `cnt` increments.
  - If `cnt`==`img_width`-1, `cnt`<=0 and state -> FLUSH1.
- Window output on accept:
  - If `cnt` before the accept is >=2, assert `win_valid` with `center_x`=`cnt`-2.
  - Otherwise `win_valid`=0.
- FLUSH1 and FLUSH2, on each clken cycle:
  - Shift with W4<=W4 (right-border replicate).
  - Assert `win_valid` with `center_x`=`img_width`-2 in FLUSH1 and `img_width`-1 in FLUSH2.
  - FLUSH2 also asserts `line_end`, then state -> IDLE.
- `col_valid` during FLUSH1/FLUSH2:
  - The column is dropped.
  - `overrun`<=1 until reset.
  - The flush continues unchanged.
- Gaps (`col_valid`=0 in RUN):
  - No shift.
  - `win_valid`<=0 on that clken cycle.
- `clken`=0: every register, including all outputs, holds its value.
- `win_out` is the registered W0..W4 after the update, so it is consistent with `center_x` in the same cycle.
- Reset mid-line: `cnt`=0, state IDLE, W and all outputs cleared. The next accepted column is treated as x=0.

## Timing
- Reset values: `win_out`=0, `win_valid`=0, `center_x`=0, `line_end`=0, `overrun`=0, state IDLE, `cnt`=0.
- All outputs are registered and update on the clken edge of the accept or flush cycle.
- Latency:
  - The window for centre x appears in the cycle after column x+2 is accepted, for x <= `img_width`-3.
  - Centres `img_width`-2 and `img_width`-1 appear on the first and second clken cycles after the last column.
- Upstream guarantees at least 2 clken cycles of blanking after the last column of each line; violations raise `overrun`.
- Windows per line: exactly `img_width`, with `center_x` strictly increasing from 0.
- `line_end` is high for exactly one clken cycle per line.

## Test plan
- Reset, then `img_width`=8, columns c0..c7 back-to-back with column k = all samples k:
  - Windows for x=0..7 appear in order.
  - x=0 window = {0,0,0,1,2}.
  - x=7 window = {5,6,7,7,7} with `line_end`=1.
  - 8 `win_valid` pulses.
- `img_width`=3:
  - Windows {0,0,0,1,2}, {0,0,1,2,2}, {0,1,2,2,2}.
  - `center_x` = 0, 1, 2.
- Random `col_valid` gaps and `clken` low cycles on a 1920-wide line:
  - Exactly 1920 windows, contents match a reference model.
  - No output changes while `clken`=0.
- `col_valid` asserted in the cycle after the last column:
  - `overrun`=1, the column is dropped.
  - The flush windows are unchanged and `overrun` stays 1.
- `rst`=1 after column 4 of a line, then restart:
  - All outputs are 0 in the cycle after reset.
  - The next column is x=0 with a replicate-filled window.
- 3-line columns (rows 0-1 zero):
  - Zero rows pass through unchanged in every window position.
